// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Brief    : Digit-scan counter, active-low anode decode, frame-synchronous
//            display-source arbiter and edit-field blink generator for a
//            multiplexed 7-segment display.
// Options  : DISP_ALARM_PRIORITY_EN - when defined, alarm_ring forces the
//            RING source at frame boundaries and the previous source is
//            restored once the alarm stops.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
    parameter int NDIG         = 12,
    parameter int BLINK_FRAMES = 42
) (
    input  logic            ckht,
    input  logic            rst,
    input  logic            ena1khz,
    input  logic            btn_mode,
    input  logic            alarm_ring,
    input  logic            edit_en,
    input  logic [3:0]      edit_pos,
    output logic [3:0]      scan_idx,
    output logic [NDIG-1:0] an,
    output logic [1:0]      src_sel,
    output logic            blank,
    output logic            frame_start
);

    // Frame counter width; at least one bit even for a single-frame period.
    localparam int              FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [3:0]      C_LAST_IDX = 4'(NDIG - 1);
    localparam logic [4:0]      C_NDIG     = 5'(NDIG);
    localparam logic [FW-1:0]   C_FC_MAX   = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_WATCH = 2'd0,
        ST_STOPW = 2'd1,
        ST_ALSET = 2'd2,
        ST_RING  = 2'd3
    } src_e;

    logic [3:0]    scan_q,      scan_d;
    src_e          state_q,     state_d;
    logic          pend_q,      pend_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q,     phase_d;
    logic          fs_q,        fs_d;
`ifdef DISP_ALARM_PRIORITY_EN
    src_e          ret_q,       ret_d;
`else
    // alarm_ring has no function in this build.
    logic          w_unused_alarm;
    assign w_unused_alarm = alarm_ring;
`endif

    logic w_boundary;
    logic w_pos_valid;

    // A frame boundary is the scan tick that takes the last digit back to 0.
    assign w_boundary  = ena1khz && (scan_q == C_LAST_IDX);
    // Out-of-range edit positions never select a digit.
    assign w_pos_valid = ({1'b0, edit_pos} < C_NDIG);

    // State register: scan counter, source FSM, blink timing, frame pulse.
    always_ff @(posedge ckht) begin
        if (rst) begin
            scan_q      <= 4'd0;
            state_q     <= ST_WATCH;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            fs_q        <= 1'b0;
`ifdef DISP_ALARM_PRIORITY_EN
            ret_q       <= ST_WATCH;
`endif
        end else begin
            scan_q      <= scan_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            fs_q        <= fs_d;
`ifdef DISP_ALARM_PRIORITY_EN
            ret_q       <= ret_d;
`endif
        end
    end

    // Scan advance, frame-start pulse and blink-phase timing.
    always_comb begin
        scan_d      = scan_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        fs_d        = w_boundary;
        if (ena1khz) begin
            scan_d = w_boundary ? 4'd0 : scan_q + 4'd1;
        end
        if (w_boundary) begin
            if (frame_cnt_q == C_FC_MAX) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Source FSM: requests latch in pend, and are acted on only at boundaries.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
`ifdef DISP_ALARM_PRIORITY_EN
        ret_d   = ret_q;
`endif
        // A press in the boundary cycle itself is folded in before the
        // boundary decision so it is consumed on that same edge.
        if (btn_mode && (state_q != ST_RING)) begin
            pend_d = 1'b1;
        end
        if (w_boundary) begin
`ifdef DISP_ALARM_PRIORITY_EN
            if (alarm_ring && (state_q != ST_RING)) begin
                ret_d   = state_q;
                state_d = ST_RING;
                pend_d  = 1'b0;
            end else if (state_q == ST_RING) begin
                if (!alarm_ring) begin
                    state_d = ret_q;
                end
            end else
`endif
            if (pend_d) begin
                pend_d = 1'b0;
                case (state_q)
                    ST_WATCH: state_d = ST_STOPW;
                    ST_STOPW: state_d = ST_ALSET;
                    default:  state_d = ST_WATCH;
                endcase
            end
        end
    end

    // Active-low one-hot anode decode from the registered scan index.
    always_comb begin
        an = '1;
        for (int i = 0; i < NDIG; i++) begin
            an[i] = (scan_q != 4'(i));
        end
    end

    // Blank the edited digit during the off half of the blink period.
    always_comb begin
        blank = edit_en && phase_q && w_pos_valid && (scan_q == edit_pos);
`ifdef DISP_ALARM_PRIORITY_EN
        if (state_q == ST_RING) begin
            blank = 1'b0;
        end
`endif
    end

    assign scan_idx    = scan_q;
    assign src_sel     = state_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire
